counter28_axil_slave: RTL and testbench

- AXI4-Lite responder (slave) carrying a 28-bit prescaled up/down counter with a four-register map; it answers the master agent that drives the S00_AXI port of the counter28 IP.
- Sits behind the block-design interconnect; also exports the live count and a terminal-count pulse to fabric logic.

---
 rtl/counter28_pkg.sv | 38 +++
 rtl/counter28_axil_slave_if.sv | 38 +++
 rtl/counter28_core.sv | 60 ++++++
 rtl/counter28_axil_slave.sv | 143 ++++++++++++++
 tb/tb_counter28_axil_slave.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/counter28_pkg.sv
// Shared register map, CTRL bit positions and write-strobe helper for the counter28 block.
// Pure constants/types; no latency or backpressure of its own.
package counter28_pkg;

    localparam int CNT_WIDTH = 28;
    localparam int PSC_WIDTH = 16;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_LOAD  = 2'd1;
    localparam logic [1:0] REG_COUNT = 2'd2;
    localparam logic [1:0] REG_PSC   = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_DIR = 1;
    localparam int CTRL_CLR = 2;
    localparam int CTRL_LD  = 3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef struct packed {
        logic ld;
        logic clr;
        logic dir;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_dat,
                                               input logic [31:0] new_dat,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_dat;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_dat[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/counter28_axil_slave_if.sv
// AXI4-Lite channel bundle between the block-design master and the counter28 responder.
// Wires only; handshakes are plain valid/ready per channel.
interface counter28_axil_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/counter28_core.sv
// Prescaled 28-bit up/down counter; CLR > LD > PRESCALE-restart > step, all one cycle.
// tc_o is registered, so it is high exactly while count_o shows the wrapped value; no backpressure.
module counter28_core
    import counter28_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic                 dir_i,
    input  logic                 clr_i,
    input  logic                 ld_i,
    input  logic                 psc_clr_i,
    input  logic [CNT_WIDTH-1:0] load_i,
    input  logic [PSC_WIDTH-1:0] prescale_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 tc_o
);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [PSC_WIDTH-1:0] psc_q, psc_d;
    logic                 tc_q, tc_d;

    always_comb begin
        cnt_d = cnt_q;
        psc_d = psc_q;
        tc_d  = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
            psc_d = '0;
        end else if (ld_i) begin
            cnt_d = load_i;
            psc_d = '0;
        end else if (psc_clr_i) begin
            psc_d = '0;
        end else if (en_i) begin
            if (psc_q == prescale_i) begin
                psc_d = '0;
                cnt_d = dir_i ? cnt_q - CNT_WIDTH'(1) : cnt_q + CNT_WIDTH'(1);
                tc_d  = dir_i ? (cnt_q == '0) : (cnt_q == '1);
            end else begin
                psc_d = psc_q + PSC_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            psc_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            psc_q <= psc_d;
            tc_q  <= tc_d;
        end
    end

    assign count_o = cnt_q;
    assign tc_o    = tc_q;

endmodule

// File: rtl/counter28_axil_slave.sv
// AXI4-Lite responder with CTRL/LOAD/COUNT/PRESCALE registers around counter28_core.
// B 1 cycle after AW+W both held, R 1 cycle after AR; one write and one read in flight, held until bready/rready.
module counter28_axil_slave
    import counter28_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
)(
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    counter28_axil_slave_if.slave s_axi,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  tc_o
);
    logic                          rdy_en_q;
    logic                          aw_vld_q, w_vld_q, b_vld_q, r_vld_q;
    logic [1:0]                    aw_idx_q;
    logic [31:0]                   w_dat_q;
    logic [3:0]                    w_strb_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_dat_q;
    ctrl_t                         ctrl_q;
    logic [CNT_WIDTH-1:0]          load_q;
    logic [PSC_WIDTH-1:0]          prescale_q;

    logic                 awready, wready, arready;
    logic                 aw_hs, w_hs, ar_hs, b_hs, r_hs, wr_fire, psc_clr;
    logic [31:0]          reg_view [4];
    logic [31:0]          wr_val;
    logic [CNT_WIDTH-1:0] count;
    logic                 unused_ok;

    // Readies stay low through reset and for the first edge after release.
    assign awready = rdy_en_q & ~aw_vld_q;
    assign wready  = rdy_en_q & ~w_vld_q;
    assign arready = rdy_en_q & ~r_vld_q;

    assign aw_hs   = s_axi.awvalid & awready;
    assign w_hs    = s_axi.wvalid  & wready;
    assign ar_hs   = s_axi.arvalid & arready;
    assign b_hs    = b_vld_q & s_axi.bready;
    assign r_hs    = r_vld_q & s_axi.rready;
    assign wr_fire = aw_vld_q & w_vld_q & ~b_vld_q;
    assign psc_clr = wr_fire & (aw_idx_q == REG_PSC);

    always_comb begin
        reg_view[REG_CTRL]  = {30'b0, ctrl_q.dir, ctrl_q.en};
        reg_view[REG_LOAD]  = {{(32-CNT_WIDTH){1'b0}}, load_q};
        reg_view[REG_COUNT] = {{(32-CNT_WIDTH){1'b0}}, count};
        reg_view[REG_PSC]   = {{(32-PSC_WIDTH){1'b0}}, prescale_q};
    end

    assign wr_val = apply_strb(reg_view[aw_idx_q], w_dat_q, w_strb_q);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rdy_en_q <= 1'b0;
            aw_vld_q <= 1'b0;
            w_vld_q  <= 1'b0;
            b_vld_q  <= 1'b0;
            r_vld_q  <= 1'b0;
            aw_idx_q <= '0;
            w_dat_q  <= '0;
            w_strb_q <= '0;
            r_dat_q  <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            if (aw_hs) begin
                aw_vld_q <= 1'b1;
                aw_idx_q <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_vld_q  <= 1'b1;
                w_dat_q  <= s_axi.wdata;
                w_strb_q <= s_axi.wstrb;
            end
            if (wr_fire) b_vld_q <= 1'b1;
            // Latches are only released once the response has been taken.
            if (b_hs) begin
                b_vld_q  <= 1'b0;
                aw_vld_q <= 1'b0;
                w_vld_q  <= 1'b0;
            end
            if (ar_hs) begin
                r_vld_q <= 1'b1;
                r_dat_q <= reg_view[s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2]];
            end else if (r_hs) begin
                r_vld_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            ctrl_q     <= '0;
            load_q     <= '0;
            prescale_q <= '0;
        end else begin
            ctrl_q.clr <= 1'b0;
            ctrl_q.ld  <= 1'b0;
            if (wr_fire) begin
                case (aw_idx_q)
                    REG_CTRL: begin
                        ctrl_q.en  <= wr_val[CTRL_EN];
                        ctrl_q.dir <= wr_val[CTRL_DIR];
                        ctrl_q.clr <= wr_val[CTRL_CLR];
                        ctrl_q.ld  <= wr_val[CTRL_LD];
                    end
                    REG_LOAD: load_q     <= wr_val[CNT_WIDTH-1:0];
                    REG_PSC:  prescale_q <= wr_val[PSC_WIDTH-1:0];
                    default:  ;
                endcase
            end
        end
    end

    counter28_core u_core (
        .clk_i      (s_axi_aclk),
        .rst_n_i    (s_axi_aresetn),
        .en_i       (ctrl_q.en),
        .dir_i      (ctrl_q.dir),
        .clr_i      (ctrl_q.clr),
        .ld_i       (ctrl_q.ld),
        .psc_clr_i  (psc_clr),
        .load_i     (load_q),
        .prescale_i (prescale_q),
        .count_o    (count),
        .tc_o       (tc_o)
    );

    assign count_o       = count;
    assign s_axi.awready = awready;
    assign s_axi.wready  = wready;
    assign s_axi.bvalid  = b_vld_q;
    assign s_axi.bresp   = RESP_OKAY;
    assign s_axi.arready = arready;
    assign s_axi.rvalid  = r_vld_q;
    assign s_axi.rdata   = r_dat_q;
    assign s_axi.rresp   = RESP_OKAY;

    assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0],
                         s_axi.araddr[1:0], wr_val[31:CNT_WIDTH]};

endmodule

// File: tb/tb_counter28_axil_slave.sv
// Directed bench for counter28_axil_slave: register access, counting, backpressure and reset.
module tb_counter28_axil_slave;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [27:0] count;
    logic        tc;
    logic [31:0] d, d2;
    int          n_chk = 0;
    int          n_pass = 0;

    counter28_axil_slave_if #(.ADDR_W(4), .DATA_W(32)) m ();

    counter28_axil_slave dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi         (m),
        .count_o       (count),
        .tc_o          (tc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] dat, input logic [3:0] s);
        bit aw_done, w_done;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        m.awaddr = a; m.wdata = dat; m.wstrb = s;
        m.awvalid = 1'b1; m.wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            if (m.awvalid && m.awready) aw_done = 1;
            if (m.wvalid && m.wready) w_done = 1;
            tick();
            if (aw_done) m.awvalid = 1'b0;
            if (w_done) m.wvalid = 1'b0;
            n++;
        end
        m.awvalid = 1'b0; m.wvalid = 1'b0;
        n = 0;
        while (!m.bvalid && n < 20) begin
            tick();
            n++;
        end
        check("wr_bvalid", 32'(m.bvalid), 32'h1);
        check("wr_bresp", 32'(m.bresp), 32'h0);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] dat);
        bit hs;
        int n;
        hs = 0; n = 0;
        m.araddr = a; m.arvalid = 1'b1;
        while (!hs && n < 20) begin
            hs = m.arready;
            tick();
            n++;
        end
        m.arvalid = 1'b0;
        n = 0;
        while (!m.rvalid && n < 20) begin
            tick();
            n++;
        end
        check("rd_rvalid", 32'(m.rvalid), 32'h1);
        check("rd_rresp", 32'(m.rresp), 32'h0);
        dat = m.rdata;
    endtask

    initial begin
        m.awaddr = '0; m.awprot = '0; m.awvalid = 1'b0;
        m.wdata = '0; m.wstrb = '0; m.wvalid = 1'b0; m.bready = 1'b1;
        m.araddr = '0; m.arprot = '0; m.arvalid = 1'b0; m.rready = 1'b1;
        #2 rst_n = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_awready", 32'(m.awready), 32'h0);
        check("rst_wready", 32'(m.wready), 32'h0);
        check("rst_arready", 32'(m.arready), 32'h0);
        check("rst_bvalid", 32'(m.bvalid), 32'h0);
        check("rst_rvalid", 32'(m.rvalid), 32'h0);
        check("rst_rdata", m.rdata, 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_tc", 32'(tc), 32'h0);
        rst_n = 1'b1;
        tick();
        check("rel_awready", 32'(m.awready), 32'h1);
        axi_read(4'h0, d); check("rst_ctrl_rd", d, 32'h0);
        axi_read(4'hC, d); check("rst_psc_rd", d, 32'h0);

        // AW one cycle ahead of W; B one cycle after the W handshake
        m.awaddr = 4'h4; m.awvalid = 1'b1;
        tick();
        m.awvalid = 1'b0;
        check("t1_aw_held", 32'(m.awready), 32'h0);
        m.wdata = 32'h00ABCDEF; m.wstrb = 4'hF; m.wvalid = 1'b1;
        tick();
        m.wvalid = 1'b0;
        check("t1_no_b_yet", 32'(m.bvalid), 32'h0);
        tick();
        check("t1_bvalid", 32'(m.bvalid), 32'h1);
        check("t1_bresp", 32'(m.bresp), 32'h0);
        tick();
        check("t1_b_done", 32'(m.bvalid), 32'h0);
        axi_read(4'h4, d); check("t1_load_rd", d, 32'h00ABCDEF);

        // Load near top, count every cycle through the wrap
        axi_write(4'h4, 32'h0FFFFFFE, 4'hF);
        axi_write(4'hC, 32'h0, 4'hF);
        axi_write(4'h0, 32'h8, 4'hF);
        tick();
        check("t2_loaded", 32'(count), 32'h0FFFFFFE);
        axi_write(4'h0, 32'h1, 4'hF);
        check("t2_c0", 32'(count), 32'h0FFFFFFE);
        tick(); check("t2_c1", 32'(count), 32'h0FFFFFFF); check("t2_tc1", 32'(tc), 32'h0);
        tick(); check("t2_c2", 32'(count), 32'h0);        check("t2_tc2", 32'(tc), 32'h1);
        tick(); check("t2_c3", 32'(count), 32'h1);        check("t2_tc3", 32'(tc), 32'h0);

        // PRESCALE=3: one step per four cycles, then freeze
        axi_write(4'h0, 32'h0, 4'hF);
        axi_write(4'h0, 32'h4, 4'hF);
        tick();
        check("t3_cleared", 32'(count), 32'h0);
        axi_write(4'hC, 32'h3, 4'hF);
        axi_write(4'h0, 32'h1, 4'hF);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t3_psc_cnt", 32'(count), 32'(k / 4));
        end
        axi_write(4'h0, 32'h0, 4'hF);
        check("t3_frozen", 32'(count), 32'h2);
        axi_read(4'h8, d);
        repeat (10) tick();
        axi_read(4'h8, d2);
        check("t3_rd1", d, 32'h2);
        check("t3_rd2", d2, 32'h2);

        // Down from zero wraps to all-ones; CLR beats LD
        axi_write(4'hC, 32'h0, 4'hF);
        axi_write(4'h0, 32'h4, 4'hF);
        tick();
        check("t4_zero", 32'(count), 32'h0);
        axi_write(4'h0, 32'h3, 4'hF);
        check("t4_start", 32'(count), 32'h0);
        tick(); check("t4_wrap", 32'(count), 32'h0FFFFFFF); check("t4_tc", 32'(tc), 32'h1);
        tick(); check("t4_next", 32'(count), 32'h0FFFFFFE); check("t4_tc_off", 32'(tc), 32'h0);
        axi_write(4'h0, 32'hC, 4'hF);
        tick();
        check("t4_clr_wins", 32'(count), 32'h0);
        check("t4_clr_no_tc", 32'(tc), 32'h0);
        axi_read(4'h0, d); check("t4_ctrl_rd", d, 32'h0);
        axi_write(4'h0, 32'h2, 4'hF);
        axi_read(4'h0, d); check("t4_dir_rd", d, 32'h2);
        axi_write(4'h8, 32'h55, 4'hF);
        axi_read(4'h8, d); check("t4_count_ro", d, 32'h0);

        // Write response backpressure
        m.bready = 1'b0;
        axi_write(4'h4, 32'h01234567, 4'hF);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_bvalid_hold", 32'(m.bvalid), 32'h1);
            check("t5_awready_low", 32'(m.awready), 32'h0);
            check("t5_wready_low", 32'(m.wready), 32'h0);
        end
        m.bready = 1'b1;
        tick();
        check("t5_b_taken", 32'(m.bvalid), 32'h0);
        check("t5_awready_back", 32'(m.awready), 32'h1);
        axi_write(4'h4, 32'hFFFFFF99, 4'b0001);
        axi_read(4'h4, d); check("t5_strb", d, 32'h01234599);
        tick();

        // Read response backpressure
        m.rready = 1'b0;
        axi_read(4'h4, d);
        check("t5_rdata", d, 32'h01234599);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_rdata_hold", m.rdata, 32'h01234599);
            check("t5_arready_low", 32'(m.arready), 32'h0);
        end
        m.rready = 1'b1;
        tick();
        check("t5_r_taken", 32'(m.rvalid), 32'h0);
        check("t5_arready_back", 32'(m.arready), 32'h1);

        // Reset with a read held and a write half accepted
        axi_write(4'h0, 32'h8, 4'hF);
        tick();
        check("t6_loaded", 32'(count), 32'h01234599);
        m.rready = 1'b0;
        axi_read(4'hC, d);
        m.awaddr = 4'hC; m.awvalid = 1'b1;
        tick();
        m.awvalid = 1'b0;
        check("t6_aw_held", 32'(m.awready), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rvalid", 32'(m.rvalid), 32'h0);
        check("t6_bvalid", 32'(m.bvalid), 32'h0);
        check("t6_awready", 32'(m.awready), 32'h0);
        check("t6_arready", 32'(m.arready), 32'h0);
        check("t6_count", 32'(count), 32'h0);
        tick();
        rst_n = 1'b1;
        m.rready = 1'b1;
        tick();
        axi_read(4'h4, d); check("t6_load_reset", d, 32'h0);
        axi_write(4'hC, 32'h1234, 4'hF);
        axi_read(4'hC, d); check("t6_psc_rd", d, 32'h1234);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
